// File: rtl/traffic_stop_monitor.sv
// traffic_stop_monitor: per-approach red-light wait counters with congestion
// flags and a single-offer valid/ack arbiter towards the light controller.
//
// Ports:
//   CLK, Reset (async, active-high)
//   Traffic, Waiting  : per-approach sensor / held-at-red inputs
//   Thresh            : congestion threshold (0 disables congestion)
//   Traffic_stop      : packed wait counters, approach i at [i*CNT_W +: CNT_W]
//   Congested         : registered congestion flags
//   Sat_sticky        : set once a counter reaches all-ones
//   Req_valid/Req_id  : offered congested approach
//   Req_ack           : controller accepts the offered approach
module traffic_stop_monitor #(
    parameter int  N_APPROACH = 4,
    parameter int  CNT_W      = 10,
    parameter int  TICK_DIV   = 1,
    localparam int ID_W       = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic [N_APPROACH-1:0]       Traffic,
    input  logic [N_APPROACH-1:0]       Waiting,
    input  logic [CNT_W-1:0]            Thresh,
    output logic [N_APPROACH*CNT_W-1:0] Traffic_stop,
    output logic [N_APPROACH-1:0]       Congested,
    output logic [N_APPROACH-1:0]       Sat_sticky,
    output logic                        Req_valid,
    output logic [ID_W-1:0]             Req_id,
    input  logic                        Req_ack
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [CNT_W-1:0]       cnt_q [N_APPROACH];
    logic [CNT_W-1:0]       cnt_d [N_APPROACH];
    logic [N_APPROACH-1:0]  cong_q, cong_d;
    logic [N_APPROACH-1:0]  sat_q, sat_d;
    logic [N_APPROACH-1:0]  hold;
    logic [N_APPROACH-1:0]  ack_clr;
    logic                   tick;
    logic                   found;
    logic [ID_W-1:0]        best_id;
    logic [CNT_W-1:0]       best_cnt;

    // Free-running time base; only Reset re-aligns it.
    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    assign hold = Traffic & Waiting;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            ack_clr[i] = Req_valid & Req_ack & (id_q == ID_W'(i));
        end
    end

    // Counter, congestion and sticky-saturation next state.
    always_comb begin
        for (int i = 0; i < N_APPROACH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ack_clr[i] || !hold[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        cong_d = '0;
        sat_d  = sat_q;
        for (int i = 0; i < N_APPROACH; i++) begin
            cong_d[i] = !ack_clr[i] && (Thresh != '0) && (cnt_q[i] >= Thresh);
            if (cnt_d[i] == CNT_MAX) begin
                sat_d[i] = 1'b1;
            end
        end
    end

    // Largest wait among congested approaches; strict '>' keeps lowest index on ties.
    always_comb begin
        found    = 1'b0;
        best_id  = '0;
        best_cnt = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            if (cong_q[i] && (!found || (cnt_q[i] > best_cnt))) begin
                found    = 1'b1;
                best_id  = ID_W'(i);
                best_cnt = cnt_q[i];
            end
        end
    end

    // Arbiter: ack wins over withdraw; returning to IDLE guarantees a gap cycle.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OFFER;
                    id_d    = best_id;
                end
            end
            OFFER: begin
                if (Req_ack || !cong_q[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            div_q   <= '0;
            cong_q  <= '0;
            sat_q   <= '0;
            for (int i = 0; i < N_APPROACH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            div_q   <= div_d;
            cong_q  <= cong_d;
            sat_q   <= sat_d;
            for (int i = 0; i < N_APPROACH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_APPROACH; g++) begin : g_pack
        assign Traffic_stop[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign Congested  = cong_q;
    assign Sat_sticky = sat_q;
    assign Req_valid  = (state_q == OFFER);
    assign Req_id     = id_q;

endmodule

// File: tb/tb_traffic_stop_monitor.sv
// tb_traffic_stop_monitor: two instances (fast / prescaled) checked every
// cycle against a behavioural model, plus directed literal checks.
module tb_traffic_stop_monitor;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  tr, wt;
    logic [3:0]  thA;
    logic [4:0]  thB;
    logic        ackA, ackB;
    logic [15:0] tsA;
    logic [19:0] tsB;
    logic [3:0]  congA, congB, satA, satB;
    logic        vA, vB;
    logic [1:0]  idA, idB;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt   [2][4];
    bit m_cong  [2][4];
    bit m_sat   [2][4];
    bit m_valid [2];
    int m_id    [2];
    int m_div   [2];

    always #5 CLK = ~CLK;

    traffic_stop_monitor #(.N_APPROACH(4), .CNT_W(4), .TICK_DIV(1)) dutA (
        .CLK(CLK), .Reset(Reset), .Traffic(tr), .Waiting(wt), .Thresh(thA),
        .Traffic_stop(tsA), .Congested(congA), .Sat_sticky(satA),
        .Req_valid(vA), .Req_id(idA), .Req_ack(ackA)
    );

    traffic_stop_monitor #(.N_APPROACH(4), .CNT_W(5), .TICK_DIV(3)) dutB (
        .CLK(CLK), .Reset(Reset), .Traffic(tr), .Waiting(wt), .Thresh(thB),
        .Traffic_stop(tsB), .Congested(congB), .Sat_sticky(satB),
        .Req_valid(vB), .Req_id(idB), .Req_ack(ackB)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_id[k]    = 0;
            m_div[k]   = 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[k][i]  = 0;
                m_cong[k][i] = 0;
                m_sat[k][i]  = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] t, input logic [3:0] w,
                              input int th, input logic ack, input int maxv,
                              input int tdiv);
        int ncnt  [4];
        bit ncong [4];
        bit tick;
        bit clr;
        int best;
        tick = (m_div[k] == tdiv - 1);
        for (int i = 0; i < 4; i++) begin
            clr = m_valid[k] && ack && (m_id[k] == i);
            if (clr || !(t[i] && w[i])) ncnt[i] = 0;
            else if (tick) ncnt[i] = (m_cnt[k][i] < maxv) ? m_cnt[k][i] + 1 : maxv;
            else ncnt[i] = m_cnt[k][i];
            ncong[i] = !clr && (th != 0) && (m_cnt[k][i] >= th);
        end
        if (m_valid[k]) begin
            if (ack || !m_cong[k][m_id[k]]) m_valid[k] = 0;
        end else begin
            best = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_cong[k][i] && (best < 0 || m_cnt[k][i] > m_cnt[k][best])) best = i;
            end
            if (best >= 0) begin
                m_valid[k] = 1;
                m_id[k]    = best;
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_cnt[k][i]  = ncnt[i];
            m_cong[k][i] = ncong[i];
            if (ncnt[i] == maxv) m_sat[k][i] = 1;
        end
        m_div[k] = (m_div[k] + 1) % tdiv;
    endtask

    task automatic check_all();
        logic [15:0] eA;
        logic [19:0] eB;
        logic [3:0]  ecA, ecB, esA, esB;
        for (int i = 0; i < 4; i++) begin
            eA[i*4 +: 4] = 4'(m_cnt[0][i]);
            eB[i*5 +: 5] = 5'(m_cnt[1][i]);
            ecA[i] = m_cong[0][i];
            ecB[i] = m_cong[1][i];
            esA[i] = m_sat[0][i];
            esB[i] = m_sat[1][i];
        end
        cmp("A.stop", 32'(tsA), 32'(eA));
        cmp("A.cong", 32'(congA), 32'(ecA));
        cmp("A.sat", 32'(satA), 32'(esA));
        cmp("A.valid", 32'(vA), 32'(m_valid[0]));
        if (m_valid[0]) cmp("A.id", 32'(idA), 32'(m_id[0]));
        cmp("B.stop", 32'(tsB), 32'(eB));
        cmp("B.cong", 32'(congB), 32'(ecB));
        cmp("B.sat", 32'(satB), 32'(esB));
        cmp("B.valid", 32'(vB), 32'(m_valid[1]));
        if (m_valid[1]) cmp("B.id", 32'(idB), 32'(m_id[1]));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step(0, tr, wt, int'(thA), ackA, 15, 1);
        model_step(1, tr, wt, int'(thB), ackB, 31, 3);
        #1 check_all();
    endtask

    // Async reset asserted between edges; outputs must clear with no clock.
    task automatic mid_reset();
        #2 Reset = 1'b1;
        #1;
        cmp("rst.A.stop", 32'(tsA), 0);
        cmp("rst.A.cong", 32'(congA), 0);
        cmp("rst.A.sat", 32'(satA), 0);
        cmp("rst.A.valid", 32'(vA), 0);
        cmp("rst.A.id", 32'(idA), 0);
        cmp("rst.B.stop", 32'(tsB), 0);
        cmp("rst.B.valid", 32'(vB), 0);
        cmp("rst.B.sat", 32'(satB), 0);
        model_reset();
        #1 Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        tr = '0; wt = '0; thA = 4'd5; thB = '0; ackA = 0; ackB = 0;
        #12 Reset = 1'b0;
        model_reset();

        // Count and clear on approach 1.
        tr = 4'b0010; wt = 4'b0010;
        repeat (7) cycle();
        cmp("lit.A.cnt1", 32'(tsA[7:4]), 7);
        cmp("lit.A.cong", 32'(congA), 32'h2);
        cmp("lit.A.valid", 32'(vA), 1);
        cmp("lit.A.id", 32'(idA), 1);
        cmp("lit.B.cnt1", 32'(tsB[9:5]), 2);
        wt = 4'b0000;
        cycle();
        cmp("lit.A.clr1", 32'(tsA[7:4]), 0);
        cycle();
        cmp("lit.A.congclr", 32'(congA), 0);

        // Load every counter, then reset mid-cycle.
        tr = 4'hF; wt = 4'hF;
        repeat (3) cycle();
        mid_reset();

        // Saturation with congestion disabled.
        thA = 0; thB = 0; tr = 4'b0001; wt = 4'b0001;
        repeat (20) cycle();
        cmp("lit.sat.cnt0", 32'(tsA[3:0]), 15);
        cmp("lit.sat.sticky", 32'(satA[0]), 1);
        cmp("lit.sat.cong", 32'(congA), 0);
        cmp("lit.sat.valid", 32'(vA), 0);
        cmp("lit.B.presc", 32'(tsB[4:0]), 6);
        mid_reset();

        // Arbitration: approach 2 at 9, approach 0 at 6.
        thA = 4'd3;
        tr = 4'b0100; wt = 4'b0100;
        repeat (3) cycle();
        tr = 4'b0101; wt = 4'b0101;
        repeat (6) cycle();
        cmp("lit.arb.cnt0", 32'(tsA[3:0]), 6);
        cmp("lit.arb.cnt2", 32'(tsA[11:8]), 9);
        cmp("lit.arb.valid", 32'(vA), 1);
        cmp("lit.arb.id", 32'(idA), 2);
        ackA = 1;
        cycle();
        ackA = 0;
        cmp("lit.ack.cnt2", 32'(tsA[11:8]), 0);
        cmp("lit.ack.cong2", 32'(congA[2]), 0);
        cmp("lit.ack.valid", 32'(vA), 0);
        cycle();
        cmp("lit.next.valid", 32'(vA), 1);
        cmp("lit.next.id", 32'(idA), 0);

        // Randomised traffic, thresholds, acks and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 11) == 0) tr[i] = ~tr[i];
                if ($urandom_range(0, 11) == 0) wt[i] = ~wt[i];
            end
            ackA = ($urandom_range(0, 3) == 0);
            ackB = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) thA = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) thB = 5'($urandom_range(0, 12));
            cycle();
            if ($urandom_range(0, 599) == 0) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_stop_monitor.md
Name: traffic_stop_monitor

Overview:
- Multi-approach successor to the single-pair traffic-stop counter.
- Per approach, counts how long detected traffic has been held at red, with a saturating count and a configurable time base.
- Flags congestion against a runtime threshold and offers one congested approach at a time to the light controller FSM over a valid/ack handshake.
- Sits between the road sensors / phase FSM and the controller's phase-request logic.

Parameters:
- N_APPROACH, 4, number of monitored approaches (2..16).
- CNT_W, 10, width of each wait counter.
- TICK_DIV, 1, clock cycles per count tick (1 = count every cycle).
- ID_W, clog2(N_APPROACH) (min 1), width of Req_id; derived, not overridden.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Traffic  in  N_APPROACH  per-approach high-traffic sensor, synchronous to CLK.
- Waiting  in  N_APPROACH  per-approach "held at red" indication from phase FSM.
- Thresh  in  CNT_W  congestion threshold; 0 disables congestion detection.
- Traffic_stop  out  N_APPROACH*CNT_W  packed wait counters, approach i at bits [i*CNT_W +: CNT_W].
- Congested  out  N_APPROACH  registered per-approach congestion flags.
- Sat_sticky  out  N_APPROACH  set when counter i reaches all-ones; cleared only by Reset.
- Req_valid  out  1  a congested approach is being offered.
- Req_id  out  ID_W  index of the offered approach.
- Req_ack  in  1  controller accepts the offer (serves that approach).

Behaviour:
- Reset (async) forces all of the following to 0: tick divider, all counters, Congested, Sat_sticky, Req_valid, Req_id; arbiter goes to IDLE. Asserting Reset mid-offer drops Req_valid immediately.
- Tick: divider counts 0..TICK_DIV-1 and tick=1 when it equals TICK_DIV-1. With TICK_DIV=1, tick is 1 every cycle. The divider free-runs and is never cleared except by Reset.
- Per approach i, with hold = Traffic[i] & Waiting[i], counter update priority is:
  1. Ack clear (Req_valid & Req_ack & Req_id==i) -> cnt <= 0.
  2. !hold -> cnt <= 0 on the next edge, independent of tick.
  3. hold & tick -> cnt <= cnt+1, saturating at 2^CNT_W-1; no wrap.
  4. hold & !tick -> hold value.
- Sat_sticky[i] sets on the edge where cnt becomes all-ones.
- Congested[i], registered from the current counter register (one-cycle lag behind Traffic_stop):
  - 0 if ack clear of i this cycle;
  - otherwise (Thresh != 0) && (cnt_q[i] >= Thresh).
  - A Thresh change takes effect on the next edge.
- Arbiter FSM has two states, IDLE and OFFER.
  - IDLE: if any Congested bit is set, choose the congested approach with the largest Traffic_stop; ties go to the lowest index. On the next edge Req_id <= choice, Req_valid <= 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: Req_id and Req_valid are held stable.
    - Req_ack=1 -> Req_valid <= 0, counter and Congested of Req_id cleared, go to IDLE.
    - Else if Congested[Req_id]=0 (traffic left or approach turned green) -> withdraw: Req_valid <= 0, go to IDLE.
    - Ack and withdraw in the same cycle: the ack is taken.
  - At least one IDLE cycle separates consecutive offers.
  - Req_ack while Req_valid=0 is ignored.
- Approaches other than Req_id keep counting during an offer.
- A newly congested approach with a higher count does not preempt an active offer.

Test Plan:
1. Reset behaviour: TICK_DIV=1, Thresh=5. Assert Reset async mid-cycle -> all outputs 0 immediately, with no clock edge needed.
2. Count and clear: Traffic[1]=Waiting[1]=1 for 7 cycles, then Waiting[1]=0 -> counter1 reads 1..7; Congested[1] rises the cycle after the count reaches 5; both counter1 and Congested[1] return to 0 on the following edges.
3. Saturation: CNT_W=4, Thresh=0, hold approach 0 for 20 cycles -> counter sticks at 15; Sat_sticky[0]=1; Congested stays 0; Req_valid never asserts.
4. Arbitration and handshake: Thresh=3, approaches 0 and 2 congested with counts 6 and 9 -> Req_valid=1, Req_id=2. Hold Req_ack=0 for 4 cycles -> Req_id stays stable. Pulse Req_ack -> counter2=0 and Congested[2]=0; after one IDLE cycle, the next offer is Req_id=0.
5. Tie and withdraw: approaches 1 and 3 both reach count 4 on the same edge -> Req_id=1. Drop Traffic[1] during the offer -> Req_valid falls without ack; the next offer is Req_id=3. Ack and withdraw in the same cycle -> the ack is honoured.
6. Prescaler: TICK_DIV=4, hold approach 0 for 16 cycles -> counter increments every 4th cycle and reaches 4. Drop hold for one cycle -> counter is cleared on the next edge, even when that cycle has no tick.
